// File: rtl/bloom_pkg.sv
// Shared types and helpers for the Bloom-filter rule writer and its lookup peer.
// Optional feature macro used by the writer: DUP_DETECT_EN (duplicate-insert flag).
package bloom_pkg;

    localparam int          KEY_W    = 104;
    localparam logic [15:0] DEF_SALT = 16'h9E37;

    // Rule tuple; ip_protocol occupies the key MSBs.
    typedef struct packed {
        logic [71:0] ip_protocol;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } rule_key_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        CLR  = 3'd4
    } wr_state_e;

    // Word index of a bit index: drop the in-word bit-select bits.
    function automatic logic [15:0] word_of(input logic [15:0] h, input int unsigned lg_w);
        return h >> lg_w;
    endfunction

    // Bit position inside the word: the low lg_w bits.
    function automatic logic [15:0] bit_of(input logic [15:0] h, input int unsigned lg_w);
        return h & ((16'd1 << lg_w) - 16'd1);
    endfunction

endpackage

// File: rtl/bloom_rule_writer_if.sv
// Rule intake, status and table-RAM port of the Bloom rule writer.
// Optional DUP_DETECT_EN adds the dup status line.
//
// Handshake: a rule transfers on a rising clk edge where in_valid and in_ready
// are both 1; in_valid asserted while in_ready is 0 is dropped, not held or queued.
// clr_req is only looked at while the writer is idle and has priority over a rule.
interface bloom_rule_writer_if #(
    parameter int IDX_W  = 10,
    parameter int WORD_W = 32
);
    localparam int AW = IDX_W - $clog2(WORD_W);

    logic [71:0]       ip_protocol;
    logic [15:0]       src_port;
    logic [15:0]       dst_port;
    logic              in_valid;
    logic              in_ready;
    logic              clr_req;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_addr;
    logic [WORD_W-1:0] mem_wr_data;
    logic [WORD_W-1:0] mem_rd_data;
    logic              busy;
    logic              done;
    logic [15:0]       insert_count;
`ifdef DUP_DETECT_EN
    logic              dup;
`endif

    // Writer side: drives the RAM bus and status.
    modport master (
`ifdef DUP_DETECT_EN
        output dup,
`endif
        input  ip_protocol, src_port, dst_port, in_valid, clr_req, mem_rd_data,
        output in_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
               busy, done, insert_count
    );

    // Control/config side plus RAM.
    modport slave (
`ifdef DUP_DETECT_EN
        input  dup,
`endif
        output ip_protocol, src_port, dst_port, in_valid, clr_req, mem_rd_data,
        input  in_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
               busy, done, insert_count
    );

endinterface

// File: rtl/bloom_hash.sv
// Combinational Bloom hash: XOR-fold of the key into IDX_W-bit chunks (from the
// LSB, last chunk zero-padded), plus i*SALT, modulo 2^IDX_W.
// The lookup path instantiates the same module so both ends agree bit-for-bit.
module bloom_hash
    import bloom_pkg::*;
#(
    parameter int          IDX_W = 10,
    parameter logic [15:0] SALT  = DEF_SALT
) (
    input  rule_key_t        i_key,
    input  logic [2:0]       i_idx,
    output logic [IDX_W-1:0] o_h
);
    localparam int NCH = (KEY_W + IDX_W - 1) / IDX_W;

    logic [NCH*IDX_W-1:0] w_padded;
    logic [IDX_W-1:0]     w_fold;
    logic [31:0]          w_salt_mul;

    // Fold the zero-padded key and add the per-hash salt offset.
    always_comb begin
        w_padded              = '0;
        w_padded[KEY_W-1:0]   = i_key;
        w_fold                = '0;
        for (int c = 0; c < NCH; c++) begin
            w_fold = w_fold ^ w_padded[c*IDX_W +: IDX_W];
        end
        w_salt_mul = 32'(i_idx) * 32'(SALT);
        o_h        = w_fold + w_salt_mul[IDX_W-1:0];
    end

endmodule

// File: rtl/bloom_rule_writer.sv
// Bloom rule writer: hashes a rule K ways and sets one table bit per hash with
// a read-modify-write on the shared word RAM; also clears the whole table.
// Optional feature macro: DUP_DETECT_EN (flags inserts whose K bits were all set).
module bloom_rule_writer
    import bloom_pkg::*;
#(
    parameter int          K      = 3,
    parameter int          IDX_W  = 10,
    parameter int          WORD_W = 32,
    parameter logic [15:0] SALT   = DEF_SALT
) (
    input  logic               clk,
    input  logic               reset,
    bloom_rule_writer_if.master bus,
    output wr_state_e          o_dbg_state
);
    localparam int LG_W  = $clog2(WORD_W);
    localparam int AW    = IDX_W - LG_W;
    localparam int DEPTH = 1 << AW;

    localparam logic [2:0]    IDX_LAST  = 3'(K - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    wr_state_e       r_state;
    rule_key_t       r_key;
    logic [2:0]      r_idx;
    logic [AW-1:0]   r_addr;
    logic [LG_W-1:0] r_bit;
    logic            r_rd_en;
    logic            r_wr_en;
    logic            r_busy;
    logic            r_in_ready;
    logic            r_done;
    logic [15:0]     r_insert_count;

    rule_key_t         w_in_key;
    rule_key_t         w_hash_key;
    logic [2:0]        w_hash_idx;
    logic [IDX_W-1:0]  w_h;
    logic [AW-1:0]     w_word;
    logic [LG_W-1:0]   w_bit;
    logic [WORD_W-1:0] w_mask;
    logic              w_bit_was_set;
    logic              w_is_dup;

    // Assemble the incoming rule tuple.
    always_comb begin
        w_in_key.ip_protocol = bus.ip_protocol;
        w_in_key.src_port    = bus.src_port;
        w_in_key.dst_port    = bus.dst_port;
    end

    // The hash always looks one step ahead: the incoming key with i=0 while idle,
    // otherwise the latched key with the next index, so the next RD address is
    // ready to be registered on the transition into RD.
    always_comb begin
        w_hash_key = (r_state == IDLE) ? w_in_key : r_key;
        w_hash_idx = (r_state == IDLE) ? 3'd0 : (r_idx + 3'd1);
    end

    bloom_hash #(
        .IDX_W (IDX_W),
        .SALT  (SALT)
    ) u_hash (
        .i_key (w_hash_key),
        .i_idx (w_hash_idx),
        .o_h   (w_h)
    );

    assign w_word        = AW'(word_of(16'(w_h), LG_W));
    assign w_bit         = LG_W'(bit_of(16'(w_h), LG_W));
    assign w_mask        = {{(WORD_W-1){1'b0}}, 1'b1} << r_bit;
    assign w_bit_was_set = bus.mem_rd_data[r_bit];

`ifdef DUP_DETECT_EN
    logic r_all_set;
    logic r_dup;
    assign w_is_dup = r_all_set & w_bit_was_set;
    assign bus.dup  = r_dup;
`else
    assign w_is_dup = 1'b0;
`endif

    // Control FSM; strobes, address and status are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_key          <= '0;
            r_idx          <= '0;
            r_addr         <= '0;
            r_bit          <= '0;
            r_rd_en        <= 1'b0;
            r_wr_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_in_ready     <= 1'b1;
            r_done         <= 1'b0;
            r_insert_count <= '0;
`ifdef DUP_DETECT_EN
            r_all_set      <= 1'b0;
            r_dup          <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clr_req) begin
                        r_state    <= CLR;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_wr_en    <= 1'b1;
                        r_addr     <= '0;
                    end else if (bus.in_valid) begin
                        r_state    <= RD;
                        r_key      <= w_in_key;
                        r_idx      <= 3'd0;
                        r_addr     <= w_word;
                        r_bit      <= w_bit;
                        r_rd_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
`ifdef DUP_DETECT_EN
                        r_all_set  <= 1'b1;
`endif
                    end
                end
                RD: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b1;
                    r_state <= WR;
                end
                WR: begin
                    r_wr_en <= 1'b0;
`ifdef DUP_DETECT_EN
                    r_all_set <= r_all_set & w_bit_was_set;
`endif
                    if (r_idx == IDX_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                        if (!w_is_dup && (r_insert_count != 16'hFFFF)) begin
                            r_insert_count <= r_insert_count + 16'd1;
                        end
`ifdef DUP_DETECT_EN
                        r_dup <= w_is_dup;
`endif
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_addr  <= w_word;
                        r_bit   <= w_bit;
                        r_rd_en <= 1'b1;
                        r_state <= RD;
                    end
                end
                CLR: begin
                    if (r_addr == ADDR_LAST) begin
                        r_wr_en        <= 1'b0;
                        r_addr         <= '0;
                        r_insert_count <= '0;
                        r_done         <= 1'b1;
                        r_state        <= DONE;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                DONE: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= IDLE;
`ifdef DUP_DETECT_EN
                    r_dup      <= 1'b0;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write data merges the just-returned read word with the bit to set;
    // clears (and every other state) write zeros.
    assign bus.mem_wr_data = (r_state == WR) ? (bus.mem_rd_data | w_mask) : '0;

    assign bus.mem_rd_en    = r_rd_en;
    assign bus.mem_wr_en    = r_wr_en;
    assign bus.mem_addr     = r_addr;
    assign bus.busy         = r_busy;
    assign bus.in_ready     = r_in_ready;
    assign bus.done         = r_done;
    assign bus.insert_count = r_insert_count;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_bloom_rule_writer.sv
// Self-checking bench for bloom_rule_writer: directed sequence with random keys,
// a behavioural bit-table model and a word RAM with one-cycle read latency.
module tb_bloom_rule_writer;
    import bloom_pkg::*;

    localparam int K      = 3;
    localparam int IDX_W  = 10;
    localparam int WORD_W = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 32;
    localparam int NBITS  = 1024;
    localparam int SALT_I = 40503;

    logic      clk = 1'b0;
    logic      reset;
    wr_state_e dbg_state;

    always #5 clk = ~clk;

    bloom_rule_writer_if #(.IDX_W(IDX_W), .WORD_W(WORD_W)) bus ();

    bloom_rule_writer #(
        .K(K), .IDX_W(IDX_W), .WORD_W(WORD_W), .SALT(16'h9E37)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Table RAM: writes land at the edge, reads return one cycle later.
    logic [WORD_W-1:0]    tb_mem [DEPTH];
    logic [AW+WORD_W-1:0] wr_log [$];
    int                   n_rd = 0;
    int                   n_wr = 0;

    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            tb_mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_log.push_back({bus.mem_addr, bus.mem_wr_data});
            n_wr <= n_wr + 1;
        end
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= tb_mem[bus.mem_addr];
            n_rd <= n_rd + 1;
        end
    end

    // Reference model state.
    bit model_bits [NBITS];
    int exp_count;
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int ref_hash(input logic [103:0] key, input int i);
        logic [IDX_W-1:0] f;
        f = '0;
        for (int j = 0; j < 104; j++) f[j % IDX_W] = f[j % IDX_W] ^ key[j];
        return (int'(f) + i * SALT_I) % NBITS;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_table(input string tag);
        int bad = 0;
        for (int w = 0; w < DEPTH; w++)
            for (int b = 0; b < WORD_W; b++)
                if (tb_mem[w][b] !== model_bits[w*WORD_W+b]) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    function automatic logic [103:0] rand_key();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[103:0];
    endfunction

    task automatic drive_key(input logic [103:0] key);
        bus.ip_protocol = key[103:32];
        bus.src_port    = key[31:16];
        bus.dst_port    = key[15:0];
    endtask

    // Insert one rule (called at a negedge while idle); optional stray in_valid
    // pulse at cycle pulse_cyc while busy. Checks latency, ready-low span, count.
    task automatic do_insert(input string tag, input logic [103:0] key, input int pulse_cyc);
        int  cyc;
        int  rlow;
        bit  seen;
        bit  all_set;
        all_set = 1'b1;
        for (int i = 0; i < K; i++) if (!model_bits[ref_hash(key, i)]) all_set = 1'b0;
        drive_key(key);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc  = 1;
        rlow = 0;
        seen = 1'b0;
        while (cyc < 100) begin
            if (!bus.in_ready) rlow++;
            if (bus.done) begin
                seen = 1'b1;
`ifdef DUP_DETECT_EN
                chk({tag, "_dup"}, 64'(bus.dup), 64'(all_set));
`endif
                break;
            end
            if (cyc == pulse_cyc) begin
                drive_key(rand_key());
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < K; i++) model_bits[ref_hash(key, i)] = 1'b1;
`ifdef DUP_DETECT_EN
        if (!all_set && exp_count < 65535) exp_count++;
`else
        if (exp_count < 65535) exp_count++;
`endif
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_lat"}, 64'(cyc), 64'(2*K+1));
        chk({tag, "_rdylow"}, 64'(rlow), 64'(2*K+1));
        chk({tag, "_count"}, 64'(bus.insert_count), 64'(exp_count));
    endtask

    // Clear the table (called at a negedge while idle), optionally with a
    // simultaneous rule that must lose to the clear.
    task automatic do_clear(input string tag, input bit with_valid);
        int cyc;
        int bad;
        int rd0;
        wr_log.delete();
        rd0 = n_rd;
        bus.clr_req = 1'b1;
        if (with_valid) begin
            drive_key(rand_key());
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.clr_req  = 1'b0;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (cyc < 200 && !bus.done) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < NBITS; i++) model_bits[i] = 1'b0;
        exp_count = 0;
        chk({tag, "_lat"}, 64'(cyc), 64'(DEPTH+1));
        chk({tag, "_nwrites"}, 64'(wr_log.size()), 64'(DEPTH));
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (a >= wr_log.size()) bad++;
            else if (wr_log[a] !== {AW'(a), {WORD_W{1'b0}}}) bad++;
        end
        chk({tag, "_writes"}, 64'(bad), 64'd0);
        chk({tag, "_count"}, 64'(bus.insert_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_nords"}, 64'(n_rd - rd0), 64'd0);
        chk({tag, "_idle"}, 64'(dbg_state), 64'(IDLE));
        chk_table({tag, "_table"});
    endtask

    initial begin
        logic [103:0] key;
        int rd0;
        int wr0;

        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.clr_req     = 1'b0;
        drive_key('0);
        exp_count       = 0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.mem_wr_data), 64'd0);
        chk("rst_count", 64'(bus.insert_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Clear, then the all-zero key (h = 0, 567, 110).
        do_clear("clr0", 1'b0);
        do_insert("zero1", 104'd0, 0);
        chk("zero_w0b0", 64'(tb_mem[0][0]), 64'd1);
        chk("zero_w17b23", 64'(tb_mem[17][23]), 64'd1);
        chk("zero_w3b14", 64'(tb_mem[3][14]), 64'd1);
        chk_table("zero1_table");
        @(negedge clk);

        // Same key again rewrites the same bits.
        do_insert("zero2", 104'd0, 0);
        chk_table("zero2_table");
        @(negedge clk);

        // Clear beats a simultaneous rule.
        do_clear("clrv", 1'b1);

        // Fixed key, with an ignored in_valid pulse while busy.
        rd0 = n_rd;
        do_insert("fixed", 104'h123456789ABC_1234_5678, 3);
        repeat (3) @(negedge clk);
        chk("fixed_rds", 64'(n_rd - rd0), 64'(K));
        chk_table("fixed_table");

        // Random keys, random stray pulses.
        for (int n = 0; n < 12; n++) begin
            do_insert("rand", rand_key(), int'($urandom_range(0, 2*K-1)));
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        chk_table("rand_table");

        // Reset during the second RD of an insert.
        key = rand_key();
        rd0 = n_rd;
        wr0 = n_wr;
        drive_key(key);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rd2", 64'(bus.mem_rd_en), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_busy", 64'(bus.busy), 64'd0);
        chk("mid_done", 64'(bus.done), 64'd0);
        chk("mid_rd_en", 64'(bus.mem_rd_en), 64'd0);
        chk("mid_wr_en", 64'(bus.mem_wr_en), 64'd0);
        chk("mid_addr", 64'(bus.mem_addr), 64'd0);
        chk("mid_wdata", 64'(bus.mem_wr_data), 64'd0);
        chk("mid_count", 64'(bus.insert_count), 64'd0);
        model_bits[ref_hash(key, 0)] = 1'b1;
        exp_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_nrd", 64'(n_rd - rd0), 64'd1);
        chk("mid_nwr", 64'(n_wr - wr0), 64'd1);
        chk_table("mid_table");
        do_insert("after_rst", rand_key(), 0);
        chk_table("after_rst_table");
        @(negedge clk);

        // Saturation via a count preload.
        force dut.r_insert_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_insert_count;
        exp_count = 16'hFFFE;
        @(negedge clk);
        do_insert("sat1", rand_key(), 0);
        @(negedge clk);
        do_insert("sat2", rand_key(), 0);
        @(negedge clk);
        do_clear("clr_sat", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
